// File: rtl/password_lockout_ctrl.sv
// Supervises the switch-password checker: arms it, counts consecutive failures,
// times the unlock window and the lockout, and clears the checker once switches are idle.
module password_lockout_ctrl #(
  parameter int MAX_FAILS = 3,
  parameter int LOCK_TIME = 30,
  parameter int OPEN_TIME = 5,
  parameter int CNT_W     = 8,
  parameter int FAIL_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              attempt_ok,
  input  logic              attempt_err,
  input  logic              sw_idle,
  output logic              chk_en,
  output logic              chk_clr,
  output logic              unlock,
  output logic              locked,
  output logic              alarm,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [CNT_W-1:0]  time_remain
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    OPEN     = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [CNT_W-1:0]  LOCK_INIT  = CNT_W'(LOCK_TIME);
  localparam logic [CNT_W-1:0]  OPEN_INIT  = CNT_W'(OPEN_TIME);

  state_t            state, state_nxt;
  logic [FAIL_W-1:0] fail_nxt;
  logic [FAIL_W-1:0] fail_inc;
  logic [CNT_W-1:0]  time_nxt;
  logic              alarm_nxt;
  logic              clr_nxt;

  assign fail_inc = fail_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARMED;
      chk_en      <= 1'b1;
      chk_clr     <= 1'b0;
      unlock      <= 1'b0;
      locked      <= 1'b0;
      alarm       <= 1'b0;
      fail_cnt    <= '0;
      time_remain <= '0;
    end else begin
      state       <= state_nxt;
      chk_en      <= (state_nxt == ARMED);
      chk_clr     <= clr_nxt;
      unlock      <= (state_nxt == OPEN);
      locked      <= (state_nxt == LOCKOUT);
      alarm       <= alarm_nxt;
      fail_cnt    <= fail_nxt;
      time_remain <= time_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fail_nxt  = fail_cnt;
    time_nxt  = time_remain;
    alarm_nxt = alarm;
    clr_nxt   = 1'b0;
    case (state)
      ARMED: begin
        // A simultaneous ok+err is scored as a failure.
        if (attempt_err) begin
          fail_nxt = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            state_nxt = LOCKOUT;
            time_nxt  = LOCK_INIT;
            alarm_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_CLR;
          end
        end else if (attempt_ok) begin
          fail_nxt  = '0;
          state_nxt = OPEN;
          time_nxt  = OPEN_INIT;
        end
      end
      OPEN: begin
        if (tick) begin
          if (time_remain <= CNT_W'(1)) begin
            time_nxt  = '0;
            state_nxt = WAIT_CLR;
          end else begin
            time_nxt = time_remain - 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (time_remain <= CNT_W'(1)) begin
            time_nxt  = '0;
            alarm_nxt = 1'b0;
            fail_nxt  = '0;
            state_nxt = WAIT_CLR;
          end else begin
            time_nxt = time_remain - 1'b1;
          end
        end
      end
      WAIT_CLR: begin
        if (sw_idle) begin
          state_nxt = ARMED;
          clr_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = ARMED;
        fail_nxt  = '0;
        time_nxt  = '0;
        alarm_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_password_lockout_ctrl.sv
// Scoreboard bench: stimulus pushes the model's expected outputs, a monitor pops and compares each cycle.
module tb_password_lockout_ctrl;

  localparam int MAX_FAILS = 3;
  localparam int LOCK_TIME = 30;
  localparam int OPEN_TIME = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       attempt_ok = 1'b0;
  logic       attempt_err = 1'b0;
  logic       sw_idle = 1'b0;
  logic       chk_en, chk_clr, unlock, locked, alarm;
  logic [1:0] fail_cnt;
  logic [7:0] time_remain;

  password_lockout_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .attempt_ok(attempt_ok),
    .attempt_err(attempt_err), .sw_idle(sw_idle), .chk_en(chk_en),
    .chk_clr(chk_clr), .unlock(unlock), .locked(locked), .alarm(alarm),
    .fail_cnt(fail_cnt), .time_remain(time_remain)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       unl;
    logic       lck;
    logic       alm;
    logic [1:0] fc;
    logic [7:0] tr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 0;

  // Reference model: what the lock is doing, in plain terms.
  string mode = "armed";
  int    m_fails = 0;
  int    m_left = 0;
  bit    m_alarm = 0;
  bit    m_clear = 0;

  task automatic model_step(input bit r, input bit t, input bit ok, input bit er, input bit idle);
    m_clear = 0;
    if (r) begin
      mode = "armed"; m_fails = 0; m_left = 0; m_alarm = 0;
    end else if (mode == "armed") begin
      if (er) begin
        m_fails++;
        if (m_fails >= MAX_FAILS) begin
          mode = "lockout"; m_left = LOCK_TIME; m_alarm = 1;
        end else mode = "wait";
      end else if (ok) begin
        m_fails = 0; mode = "open"; m_left = OPEN_TIME;
      end
    end else if (mode == "open" || mode == "lockout") begin
      if (t && m_left > 0) m_left--;
      if (m_left == 0) begin
        if (mode == "lockout") begin m_alarm = 0; m_fails = 0; end
        mode = "wait";
      end
    end else if (idle) begin
      mode = "armed"; m_clear = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit ok, input bit er, input bit idle);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; attempt_ok = ok; attempt_err = er; sw_idle = idle;
    model_step(r, t, ok, er, idle);
    e.en  = (mode == "armed");
    e.clr = m_clear;
    e.unl = (mode == "open");
    e.lck = (mode == "lockout");
    e.alm = m_alarm;
    e.fc  = 2'(m_fails);
    e.tr  = 8'(m_left);
    exp_q.push_back(e);
  endtask

  // Monitor: the DUT presents a registered output word every cycle.
  initial begin
    exp_t got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {chk_en, chk_clr, unlock, locked, alarm, fail_cnt, time_remain};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs @%0t: got en=%b clr=%b unl=%b lck=%b alm=%b fc=%0d tr=%0d, want en=%b clr=%b unl=%b lck=%b alm=%b fc=%0d tr=%0d",
                   $time, got.en, got.clr, got.unl, got.lck, got.alm, got.fc, got.tr,
                   want.en, want.clr, want.unl, want.lck, want.alm, want.fc, want.tr);
        end
      end
    end
  end

  initial begin
    // 1: reset, unlock, time out, clear
    cyc(1,0,0,0,0); cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,0,0,0);
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,0);
    cyc(0,0,0,0,0); cyc(0,0,0,0,1); cyc(0,0,0,0,1); cyc(0,0,0,0,0);
    // 2: two failures then success
    for (int i = 0; i < 2; i++) begin cyc(0,0,0,1,0); cyc(0,0,0,0,1); end
    cyc(0,0,1,0,0); cyc(0,1,0,0,0);
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,1);
    cyc(0,0,0,0,1);
    // 3: lockout full duration, attempts ignored (4)
    for (int i = 0; i < 3; i++) begin cyc(0,0,0,1,0); cyc(0,0,0,0,1); end
    cyc(0,0,1,1,0); cyc(0,0,1,0,0);
    for (int i = 0; i < 29; i++) cyc(0,1,0,0,0);
    cyc(0,0,0,0,1); cyc(0,1,0,0,0); cyc(0,0,0,0,1);
    // 4: ok+err together counts as failure
    cyc(0,0,1,1,0); cyc(0,0,0,0,1);
    // 5: reset mid-lockout at 12 remaining
    cyc(0,0,0,1,0); cyc(0,0,0,0,1); cyc(0,0,0,1,0);
    for (int i = 0; i < 18; i++) cyc(0,1,0,0,0);
    cyc(1,0,0,0,0); cyc(0,0,0,0,0);
    // 6: idle held through OPEN exit
    cyc(0,0,1,0,1);
    for (int i = 0; i < 5; i++) cyc(0,1,0,0,1);
    cyc(0,0,0,0,1); cyc(0,0,0,0,1); cyc(0,0,0,0,1);
    // random traffic
    for (int i = 0; i < 4000; i++)
      cyc(($urandom_range(0,299) == 0), ($urandom_range(0,3) == 0),
          ($urandom_range(0,7) == 0), ($urandom_range(0,5) == 0),
          ($urandom_range(0,1) == 0));
    cyc(0,0,0,0,0);
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
